// File: rtl/led_scan_controller.sv
// LED bar scanner: IDLE/RUN sequencer, prescaled step tick, bounce/wrap/blink patterns,
// and a ready/valid config port whose RUN-time updates take effect on the next tick.
module led_scan_controller #(
  parameter int TICK_DIV_W = 23,
  parameter int NUM_LEDS   = 10
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                run,
  input  logic [1:0]          cfg_mode,
  input  logic [2:0]          cfg_speed,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [NUM_LEDS-1:0] LEDR,
  output logic [3:0]          pos,
  output logic                tick,
  output logic                busy
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [3:0]            LAST     = 4'(NUM_LEDS - 1);
  localparam logic [TICK_DIV_W-1:0] PRESC_MAX = '1;
  localparam logic [NUM_LEDS-1:0]   LED_ONE  = NUM_LEDS'(1);

  state_t                state_q, state_d;
  logic [TICK_DIV_W-1:0] presc_q, presc_d;
  logic [3:0]            pos_q, pos_d;
  logic                  dir_up_q, dir_up_d;
  logic                  tick_q, tick_d;
  logic                  busy_q, busy_d;
  logic [NUM_LEDS-1:0]   led_q, led_d;
  logic [1:0]            mode_act_q, mode_act_d;
  logic [2:0]            speed_act_q, speed_act_d;
  logic                  pend_q, pend_d;
  logic [1:0]            pend_mode_q, pend_mode_d;
  logic [2:0]            pend_speed_q, pend_speed_d;

  logic                  accept;
  logic                  term_cnt;
  logic [TICK_DIV_W-1:0] limit;

  assign cfg_ready = (state_q == S_IDLE) || !pend_q;
  assign accept    = cfg_valid && cfg_ready;
  assign limit     = PRESC_MAX >> speed_act_q;
  assign term_cnt  = (presc_q == limit);

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    pos_d        = pos_q;
    dir_up_d     = dir_up_q;
    tick_d       = 1'b0;
    mode_act_d   = mode_act_q;
    speed_act_d  = speed_act_q;
    pend_d       = pend_q;
    pend_mode_d  = pend_mode_q;
    pend_speed_d = pend_speed_q;

    case (state_q)
      S_IDLE: begin
        presc_d  = '0;
        pos_d    = '0;
        dir_up_d = 1'b1;
        if (accept) begin
          mode_act_d  = cfg_mode;
          speed_act_d = cfg_speed;
        end
        if (run) state_d = S_RUN;
      end
      S_RUN: begin
        if (!run) begin
          state_d  = S_IDLE;
          presc_d  = '0;
          pos_d    = '0;
          dir_up_d = 1'b1;
          // Leaving RUN: a pending or simultaneous config goes live immediately.
          if (pend_q) begin
            mode_act_d  = pend_mode_q;
            speed_act_d = pend_speed_q;
            pend_d      = 1'b0;
          end else if (accept) begin
            mode_act_d  = cfg_mode;
            speed_act_d = cfg_speed;
          end
        end else begin
          presc_d = presc_q + 1'b1;
          if (accept) begin
            pend_d       = 1'b1;
            pend_mode_d  = cfg_mode;
            pend_speed_d = cfg_speed;
          end
          if (term_cnt) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (pend_q) begin
              mode_act_d  = pend_mode_q;
              speed_act_d = pend_speed_q;
              pend_d      = 1'b0;
              pos_d       = '0;
              dir_up_d    = 1'b1;
            end else begin
              case (mode_act_q)
                2'b00: begin
                  if (dir_up_q) begin
                    if (pos_q >= LAST) begin
                      pos_d    = LAST - 4'd1;
                      dir_up_d = 1'b0;
                    end else begin
                      pos_d = pos_q + 4'd1;
                    end
                  end else begin
                    if (pos_q == 4'd0) begin
                      pos_d    = 4'd1;
                      dir_up_d = 1'b1;
                    end else begin
                      pos_d = pos_q - 4'd1;
                    end
                  end
                end
                2'b01:   pos_d = (pos_q >= LAST) ? 4'd0 : pos_q + 4'd1;
                2'b10:   pos_d = (pos_q == 4'd0 || pos_q > LAST) ? LAST : pos_q - 4'd1;
                default: pos_d = (pos_q == 4'd0) ? 4'd1 : 4'd0;
              endcase
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    if (state_d != S_RUN) begin
      led_d = '0;
    end else if (mode_act_d == 2'b11) begin
      led_d = (pos_d == 4'd0) ? '1 : '0;
    end else begin
      led_d = LED_ONE << pos_d;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      pos_q        <= '0;
      dir_up_q     <= 1'b1;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      led_q        <= '0;
      mode_act_q   <= 2'b00;
      speed_act_q  <= 3'd0;
      pend_q       <= 1'b0;
      pend_mode_q  <= 2'b00;
      pend_speed_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      pos_q        <= pos_d;
      dir_up_q     <= dir_up_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
      led_q        <= led_d;
      mode_act_q   <= mode_act_d;
      speed_act_q  <= speed_act_d;
      pend_q       <= pend_d;
      pend_mode_q  <= pend_mode_d;
      pend_speed_q <= pend_speed_d;
    end
  end

  assign LEDR = led_q;
  assign pos  = pos_q;
  assign tick = tick_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_led_scan_controller.sv
// Directed bench for led_scan_controller at TICK_DIV_W=4, NUM_LEDS=10.
module tb_led_scan_controller;
  localparam int W = 4;
  localparam int N = 10;

  logic         clk = 1'b0;
  logic         reset, run, cfg_valid;
  logic [1:0]   cfg_mode;
  logic [2:0]   cfg_speed;
  logic         cfg_ready;
  logic [N-1:0] ledr;
  logic [3:0]   pos;
  logic         tick, busy;

  led_scan_controller #(.TICK_DIV_W(W), .NUM_LEDS(N)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .run      (run),
    .cfg_mode (cfg_mode),
    .cfg_speed(cfg_speed),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .LEDR     (ledr),
    .pos      (pos),
    .tick     (tick),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  speed;
    int          period;
    int          nticks;
    logic [79:0] seq;   // expected pos after each tick, first tick in the top used nibble
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [N-1:0] led_model(input logic [1:0] m, input logic [3:0] p);
    logic [N-1:0] one;
    one = 1;
    if (m == 2'b11) return (p == 4'd0) ? '1 : '0;
    return one << p;
  endfunction

  task automatic wait_tick(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tick && cyc < budget);
    if (!tick) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_speed = 3'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic start(input logic [1:0] m, input logic [2:0] s);
    cfg_valid = 1'b1; cfg_mode = m; cfg_speed = s;
    @(negedge clk);
    cfg_valid = 1'b0;
    run = 1'b1;
    @(negedge clk);
    chk("entry_busy", 32'(busy), 32'd1);
    chk("entry_pos", 32'(pos), 32'd0);
    chk("entry_ledr", 32'(ledr), 32'(led_model(m, 4'd0)));
    chk("entry_tick", 32'(tick), 32'd0);
  endtask

  initial begin
    int c;
    int nt;
    logic [3:0] ep;

    vecs[0] = '{mode: 2'b00, speed: 3'd0, period: 16, nticks: 19, seq: 80'h1234567898765432101};
    vecs[1] = '{mode: 2'b01, speed: 3'd2, period: 4,  nticks: 11, seq: 80'h12345678901};
    vecs[2] = '{mode: 2'b10, speed: 3'd2, period: 4,  nticks: 11, seq: 80'h98765432109};
    vecs[3] = '{mode: 2'b11, speed: 3'd1, period: 8,  nticks: 4,  seq: 80'h1010};
    vecs[4] = '{mode: 2'b01, speed: 3'd7, period: 1,  nticks: 3,  seq: 80'h123};

    reset = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_speed = 3'd0;
    @(negedge clk);
    chk("rst_ledr", 32'(ledr), 32'd0);
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      start(vecs[v].mode, vecs[v].speed);
      for (int k = 0; k < vecs[v].nticks; k++) begin
        ep = vecs[v].seq[4*(vecs[v].nticks-1-k) +: 4];
        wait_tick(vecs[v].period + 2, c);
        chk($sformatf("v%0d_t%0d_period", v, k), 32'(c), 32'(vecs[v].period));
        chk($sformatf("v%0d_t%0d_pos", v, k), 32'(pos), 32'(ep));
        chk($sformatf("v%0d_t%0d_ledr", v, k), 32'(ledr), 32'(led_model(vecs[v].mode, ep)));
      end
    end

    // Config offered mid-period while running.
    do_reset();
    start(2'b01, 3'd0);
    repeat (3) @(negedge clk);
    cfg_valid = 1'b1; cfg_mode = 2'b11; cfg_speed = 3'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("hs_ready_drop", 32'(cfg_ready), 32'd0);
    wait_tick(20, c);
    chk("hs_first_gap", 32'(c), 32'd12);
    chk("hs_ledr0", 32'(ledr), 32'h3FF);
    chk("hs_pos0", 32'(pos), 32'd0);
    chk("hs_ready_back", 32'(cfg_ready), 32'd1);
    wait_tick(20, c);
    chk("hs_period", 32'(c), 32'd16);
    chk("hs_ledr1", 32'(ledr), 32'h000);
    wait_tick(20, c);
    chk("hs_ledr2", 32'(ledr), 32'h3FF);

    // Config accepted on the terminal-count edge.
    do_reset();
    start(2'b01, 3'd0);
    repeat (15) @(negedge clk);
    cfg_valid = 1'b1; cfg_mode = 2'b10; cfg_speed = 3'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("tc_tick", 32'(tick), 32'd1);
    chk("tc_old_step", 32'(pos), 32'd1);
    chk("tc_pending", 32'(cfg_ready), 32'd0);
    wait_tick(20, c);
    chk("tc_period", 32'(c), 32'd16);
    chk("tc_apply_pos", 32'(pos), 32'd0);
    chk("tc_apply_ledr", 32'(ledr), 32'h001);
    wait_tick(20, c);
    chk("tc_new_mode", 32'(pos), 32'd9);

    // run dropped mid-scan, then reasserted.
    do_reset();
    start(2'b00, 3'd0);
    wait_tick(20, c);
    repeat (5) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_ledr", 32'(ledr), 32'd0);
    chk("stop_pos", 32'(pos), 32'd0);
    chk("stop_tick", 32'(tick), 32'd0);
    run = 1'b1;
    @(negedge clk);
    chk("rerun_ledr", 32'(ledr), 32'h001);
    chk("rerun_busy", 32'(busy), 32'd1);
    nt = 0;
    repeat (15) begin
      @(negedge clk);
      if (tick) nt++;
    end
    chk("rerun_no_tick", 32'(nt), 32'd0);
    @(negedge clk);
    chk("rerun_tick16", 32'(tick), 32'd1);
    chk("rerun_pos", 32'(pos), 32'd1);

    // run dropped while a config is pending.
    do_reset();
    start(2'b00, 3'd0);
    repeat (4) @(negedge clk);
    cfg_valid = 1'b1; cfg_mode = 2'b11; cfg_speed = 3'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("pstop_pending", 32'(cfg_ready), 32'd0);
    run = 1'b0;
    @(negedge clk);
    chk("pstop_busy", 32'(busy), 32'd0);
    chk("pstop_ready", 32'(cfg_ready), 32'd1);
    run = 1'b1;
    @(negedge clk);
    chk("pstop_applied", 32'(ledr), 32'h3FF);

    // Asynchronous reset between edges with a config pending.
    do_reset();
    start(2'b01, 3'd0);
    repeat (2) @(negedge clk);
    cfg_valid = 1'b1; cfg_mode = 2'b11; cfg_speed = 3'd2;
    @(negedge clk);
    cfg_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_ledr", 32'(ledr), 32'd0);
    chk("arst_pos", 32'(pos), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("arst_resume_busy", 32'(busy), 32'd1);
    chk("arst_resume_ledr", 32'(ledr), 32'h001);
    wait_tick(20, c);
    chk("arst_period", 32'(c), 32'd16);
    chk("arst_pos1", 32'(pos), 32'd1);
    chk("arst_ledr1", 32'(ledr), 32'h002);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
